// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver with its own baud-tick divider.
//   Deframes 8N1 (or 8E1 when UART_RX_PARITY_EN is defined) bytes, LSB first.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   rx         - serial line, idle high, asynchronous to clk
//   d_out      - last correctly framed byte, held until the next good frame
//   rx_done    - one-clock strobe, d_out valid in the same cycle
//   frame_err  - one-clock strobe, stop bit sampled low
//   parity_err - one-clock strobe with rx_done on parity mismatch (0 without macro)
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit after the data).
module uart_rx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned DIVISOR = 163
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   output logic [DBIT-1:0] d_out,
   output logic            rx_done,
   output logic            frame_err,
   output logic            parity_err
);

   localparam int unsigned DIV_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
   localparam int unsigned N_W   = (DBIT > 2) ? $clog2(DBIT) : 1;
   localparam int unsigned S_W   = 4;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

   state_t            state_q, state_d;
   logic [S_W-1:0]    s_q, s_d;
   logic [N_W-1:0]    n_q, n_d;
   logic [DBIT-1:0]   sh_q, sh_d;
   logic [DBIT-1:0]   d_out_d;
   logic              rx_done_d, frame_err_d;
   logic              rx_meta, rx_s;
   logic [DIV_W-1:0]  div_q;
   logic              tick;

   // Two-flop synchronizer; resets to the idle-high line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Free-running oversample tick divider; never re-aligned to the line.
   assign tick = (div_q == DIV_W'(DIVISOR - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) div_q <= '0;
      else       div_q <= tick ? '0 : div_q + DIV_W'(1);
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d, parity_err_d;
`endif

   // State and registered-output update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         s_q       <= '0;
         n_q       <= '0;
         sh_q      <= '0;
         d_out     <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q  <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         sh_q      <= sh_d;
         d_out     <= d_out_d;
         rx_done   <= rx_done_d;
         frame_err <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q  <= par_bad_d;
         parity_err <= parity_err_d;
`endif
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   // Next-state and strobe logic.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      n_d         = n_q;
      sh_d        = sh_q;
      d_out_d     = d_out;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            // Re-check the line half a bit in to reject glitches.
            if (tick) begin
               if (s_q == S_W'(7)) begin
                  if (rx_s) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_q == S_W'(15)) begin
                  sh_d = {rx_s, sh_q[DBIT-1:1]};
                  s_d  = '0;
                  if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_d = n_q + N_W'(1);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            // Even parity: received bit must equal XOR of the data bits.
            if (tick) begin
               if (s_q == S_W'(15)) begin
                  par_bad_d = rx_s ^ (^sh_q);
                  s_d       = '0;
                  state_d   = STOP;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (s_q == S_W'(SB_TICK - 1)) begin
                  if (rx_s) begin
                     d_out_d   = sh_q;
                     rx_done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err_d = par_bad_q;
`endif
                     state_d   = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = BRK;
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         BRK: begin
            // Swallow a held-low line so it yields a single frame_err.
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with DIVISOR=4 (64 clk per bit).
//   Stimulus pushes expected strobe events; a negedge monitor pops and compares.
module tb_uart_rx;

   localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct packed {
      logic       done;
      logic       ferr;
      logic       perr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] d_out;
   logic       rx_done, frame_err, parity_err;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         n_vec = 0;
   int         n_miss = 0;
   logic [7:0] last_good = 8'h00;

   uart_rx #(.DBIT(8), .SB_TICK(16), .DIVISOR(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .d_out      (d_out),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   // Monitor: every strobe must match the next expected event.
   always @(negedge clk) begin
      if (!reset && (rx_done || frame_err || parity_err)) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_strobe: got done=%b ferr=%b perr=%b d_out=%02h, required no strobe",
                     rx_done, frame_err, parity_err, d_out);
         end else begin
            mon_e = exp_q.pop_front();
            if (rx_done !== mon_e.done || frame_err !== mon_e.ferr ||
                parity_err !== mon_e.perr || d_out !== mon_e.data) begin
               n_miss++;
               $display("FAIL strobe_event: got done=%b ferr=%b perr=%b d_out=%02h, required done=%b ferr=%b perr=%b d_out=%02h",
                        rx_done, frame_err, parity_err, d_out,
                        mon_e.done, mon_e.ferr, mon_e.perr, mon_e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
      n_vec++;
      if (got !== req) begin
         n_miss++;
         $display("FAIL %s: got %02h, required %02h", name, got, req);
      end
   endtask

   task automatic line(input logic v, input int clks);
      rx = v;
      repeat (clks) @(posedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input logic has_par, input logic par,
                            input logic stop_bit);
      line(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) line(b[i], BIT_CLK);
      if (has_par) line(par, BIT_CLK);
      line(stop_bit, BIT_CLK);
   endtask

   // Good frame with correct parity; expectation queued before sending.
   task automatic send_good(input logic [7:0] b);
      exp_q.push_back('{done: 1'b1, ferr: 1'b0, perr: 1'b0, data: b});
      last_good = b;
      send_bits(b, PAR_EN, ^b, 1'b1);
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL %s: %0d expected strobes missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset_d_out", d_out, 8'h00);
      check("reset_rx_done", 8'(rx_done), 8'h00);
      check("reset_frame_err", 8'(frame_err), 8'h00);
      check("reset_parity_err", 8'(parity_err), 8'h00);
      reset = 1'b0;
      line(1'b1, 4 * BIT_CLK);

      // 1: single byte
      send_good(8'h02);
      line(1'b1, 2 * BIT_CLK);
      wait_drain("t1_byte_02");

      // 2: back-to-back frames, no idle gap
      send_good(8'h00);
      send_good(8'h0F);
      send_good(8'h18);
      line(1'b1, 2 * BIT_CLK);
      wait_drain("t2_back_to_back");

      // 3: short glitch rejected, then a real frame
      line(1'b0, 12);
      line(1'b1, 3 * BIT_CLK);
      send_good(8'h04);
      line(1'b1, 2 * BIT_CLK);
      wait_drain("t3_glitch_then_04");

      // 4: framing error with long break; d_out keeps the prior byte
      exp_q.push_back('{done: 1'b0, ferr: 1'b1, perr: 1'b0, data: last_good});
      send_bits(8'hA5, PAR_EN, ^8'hA5, 1'b0);
      line(1'b0, 19 * BIT_CLK);
      line(1'b1, 3 * BIT_CLK);
      @(negedge clk);
      check("t4_d_out_held", d_out, 8'h04);
      send_good(8'h55);
      line(1'b1, 2 * BIT_CLK);
      wait_drain("t4_break_then_55");

      // 5: reset during bit 3 of 0x3C, frame abandoned
      line(1'b0, BIT_CLK);
      line(1'b0, BIT_CLK);
      line(1'b0, BIT_CLK);
      line(1'b1, BIT_CLK);
      line(1'b1, BIT_CLK / 2);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t5_reset_d_out", d_out, 8'h00);
      check("t5_reset_strobes", {5'b0, rx_done, frame_err, parity_err}, 8'h00);
      reset = 1'b0;
      line(1'b1, 4 * BIT_CLK);
      send_good(8'h81);
      line(1'b1, 2 * BIT_CLK);
      wait_drain("t5_after_reset_81");

`ifdef UART_RX_PARITY_EN
      // 6: parity mismatch flagged alongside rx_done, then a clean frame
      exp_q.push_back('{done: 1'b1, ferr: 1'b0, perr: 1'b1, data: 8'h07});
      send_bits(8'h07, 1'b1, 1'b0, 1'b1);
      line(1'b1, 2 * BIT_CLK);
      exp_q.push_back('{done: 1'b1, ferr: 1'b0, perr: 1'b0, data: 8'h07});
      send_bits(8'h07, 1'b1, 1'b1, 1'b1);
      line(1'b1, 2 * BIT_CLK);
      wait_drain("t6_parity");
`endif

      check("final_d_out", d_out, PAR_EN ? 8'h07 : 8'h81);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
